// File: rtl/sync_frame_tx_pkg.sv
// sync_frame_tx_pkg
// Shared definitions for the sync-link framer. The receive side imports the
// same package so both ends agree on the sync pattern and state encodings.
//   BYTE_W            payload byte width
//   NDATA_DEFAULT     default sync word length in bits
//   SYNC_WORD_DEFAULT default sync pattern, sent MSB first
//   state_t           framer state encodings (3-bit)
package sync_frame_tx_pkg;

  localparam int BYTE_W        = 8;
  localparam int NDATA_DEFAULT = 128;

  localparam logic [127:0] SYNC_WORD_DEFAULT = {8{16'hA5C3}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_FETCH = 3'd2,
    ST_DATA  = 3'd3,
    ST_TAIL  = 3'd4
  } state_t;

endpackage

// File: rtl/sync_frame_tx.sv
// sync_frame_tx
// Transmit-side framer: sends an NDATA-bit sync word (MSB first), then len
// payload bytes (MSB first), one bit per bit_tick, then holds the last bit for
// one more tick period before closing the frame.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      frame request, honoured only when idle
//   len        payload byte count, captured with start (0 = sync word only)
//   bit_tick   one-cycle bit-period strobe
//   din        payload byte
//   din_valid  din holds a byte
//   din_ready  framer accepts din this cycle
//   tx_out     serial line bit (registered, idle level 0)
//   tx_active  a frame is in progress
//   done       one-cycle pulse on normal frame completion
//   underrun   sticky: last frame aborted for lack of data
module sync_frame_tx
  import sync_frame_tx_pkg::*;
#(
  parameter int               NDATA     = NDATA_DEFAULT,
  parameter logic [NDATA-1:0] SYNC_WORD = SYNC_WORD_DEFAULT[NDATA-1:0]
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] len,
  input  logic       bit_tick,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       tx_out,
  output logic       tx_active,
  output logic       done,
  output logic       underrun
);

  // Index width into the sync word; the bit counter also walks byte bits,
  // so it never gets narrower than 4 bits even for very short sync words.
  localparam int IW = (NDATA > 1) ? $clog2(NDATA) : 1;
  localparam int CW = ((IW + 1) > 4) ? (IW + 1) : 4;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0]    bytes_left_r, bytes_left_nxt_s;
  logic [7:0]    shreg_r, shreg_nxt_s;
  logic          tx_out_r, tx_out_nxt_s;
  logic          tx_active_r, tx_active_nxt_s;
  logic          done_r, done_nxt_s;
  logic          underrun_r, underrun_nxt_s;
  logic          din_ready_r;

  logic [IW-1:0] sync_idx_s;
  logic [2:0]    byte_idx_s;
  logic [7:0]    bytes_dec_s;
  logic          handshake_s;

  assign sync_idx_s  = IW'(NDATA - 1) - bit_cnt_r[IW-1:0];
  assign byte_idx_s  = 3'(BYTE_W - 1) - bit_cnt_r[2:0];
  assign bytes_dec_s = bytes_left_r - 8'd1;
  assign handshake_s = din_valid & din_ready_r;

  // Next-state and next-datapath logic for the framer.
  always_comb begin
    state_nxt_s      = state_r;
    bit_cnt_nxt_s    = bit_cnt_r;
    bytes_left_nxt_s = bytes_left_r;
    shreg_nxt_s      = shreg_r;
    tx_out_nxt_s     = tx_out_r;
    tx_active_nxt_s  = tx_active_r;
    done_nxt_s       = 1'b0;
    underrun_nxt_s   = underrun_r;
    case (state_r)
      ST_IDLE: begin
        tx_out_nxt_s = 1'b0;
        // A tick coinciding with start is deliberately dropped here.
        if (start) begin
          bytes_left_nxt_s = len;
          bit_cnt_nxt_s    = '0;
          underrun_nxt_s   = 1'b0;
          tx_active_nxt_s  = 1'b1;
          state_nxt_s      = ST_SYNC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (bit_tick) begin
          tx_out_nxt_s  = SYNC_WORD[sync_idx_s];
          bit_cnt_nxt_s = bit_cnt_r + CW'(1);
          if (bit_cnt_r == CW'(NDATA - 1)) begin
            if (bytes_left_r != 8'd0) begin
              state_nxt_s = ST_FETCH;
            end else begin
              state_nxt_s = ST_TAIL;
            end
          end else begin
            state_nxt_s = ST_SYNC;
          end
        end else begin
          state_nxt_s = ST_SYNC;
        end
      end
      ST_FETCH: begin
        if (handshake_s) begin
          shreg_nxt_s = din;
          state_nxt_s = ST_DATA;
          // Same-cycle tick sends the MSB straight from din to avoid a gap.
          if (bit_tick) begin
            tx_out_nxt_s  = din[7];
            bit_cnt_nxt_s = CW'(1);
          end else begin
            bit_cnt_nxt_s = '0;
          end
        end else if (bit_tick) begin
          tx_out_nxt_s    = 1'b0;
          underrun_nxt_s  = 1'b1;
          tx_active_nxt_s = 1'b0;
          state_nxt_s     = ST_IDLE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          tx_out_nxt_s  = shreg_r[byte_idx_s];
          bit_cnt_nxt_s = bit_cnt_r + CW'(1);
          if (bit_cnt_r == CW'(BYTE_W - 1)) begin
            bytes_left_nxt_s = bytes_dec_s;
            if (bytes_dec_s != 8'd0) begin
              state_nxt_s = ST_FETCH;
            end else begin
              state_nxt_s = ST_TAIL;
            end
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_TAIL: begin
        // Last bit has been held for a full period; close the frame.
        if (bit_tick) begin
          tx_out_nxt_s    = 1'b0;
          tx_active_nxt_s = 1'b0;
          done_nxt_s      = 1'b1;
          state_nxt_s     = ST_IDLE;
        end else begin
          state_nxt_s = ST_TAIL;
        end
      end
      default: begin
        tx_out_nxt_s    = 1'b0;
        tx_active_nxt_s = 1'b0;
        state_nxt_s     = ST_IDLE;
      end
    endcase
  end

  // Framer registers; rst has priority over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= '0;
      bytes_left_r <= 8'd0;
      shreg_r      <= 8'd0;
      tx_out_r     <= 1'b0;
      tx_active_r  <= 1'b0;
      done_r       <= 1'b0;
      underrun_r   <= 1'b0;
      din_ready_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      bit_cnt_r    <= bit_cnt_nxt_s;
      bytes_left_r <= bytes_left_nxt_s;
      shreg_r      <= shreg_nxt_s;
      tx_out_r     <= tx_out_nxt_s;
      tx_active_r  <= tx_active_nxt_s;
      done_r       <= done_nxt_s;
      underrun_r   <= underrun_nxt_s;
      // Registered decode: high exactly while the framer sits in FETCH.
      din_ready_r  <= (state_nxt_s == ST_FETCH);
    end
  end

  assign din_ready = din_ready_r;
  assign tx_out    = tx_out_r;
  assign tx_active = tx_active_r;
  assign done      = done_r;
  assign underrun  = underrun_r;

endmodule

// File: tb/tb_sync_frame_tx.sv
// tb_sync_frame_tx
// Directed bench for sync_frame_tx: a 16-bit sync instance (A5C3) for the
// nominal, sync-only, underrun, start-handling and reset cases, and a
// 128-bit default instance for max-rate back-to-back framing.
module tb_sync_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_a, start_b, bit_tick, din_valid, sel;
  logic [7:0] din, len;
  logic din_ready_a, tx_out_a, tx_active_a, done_a, underrun_a;
  logic din_ready_b, tx_out_b, tx_active_b, done_b, underrun_b;
  logic o_ready, o_tx, o_active, o_done, o_underrun;

  sync_frame_tx #(.NDATA(16), .SYNC_WORD(16'hA5C3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .len(len), .bit_tick(bit_tick),
    .din(din), .din_valid(din_valid), .din_ready(din_ready_a),
    .tx_out(tx_out_a), .tx_active(tx_active_a), .done(done_a),
    .underrun(underrun_a));

  sync_frame_tx #(.NDATA(128), .SYNC_WORD({8{16'hA5C3}})) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .len(len), .bit_tick(bit_tick),
    .din(din), .din_valid(din_valid), .din_ready(din_ready_b),
    .tx_out(tx_out_b), .tx_active(tx_active_b), .done(done_b),
    .underrun(underrun_b));

  assign o_ready    = sel ? din_ready_b : din_ready_a;
  assign o_tx       = sel ? tx_out_b    : tx_out_a;
  assign o_active   = sel ? tx_active_b : tx_active_a;
  assign o_done     = sel ? done_b      : done_a;
  assign o_underrun = sel ? underrun_b  : underrun_a;

  int          checks = 0;
  int          errors = 0;
  int          ptr;
  int          done_cnt;
  logic        saw_ready;
  logic [7:0]  src [256];
  logic        last_tx, last_active, last_done, last_underrun;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; tracks byte handshakes so din walks through src.
  task automatic cyc();
    logic hs;
    hs = din_valid & o_ready;
    @(posedge clk);
    #1;
    if (hs) begin
      ptr++;
      din = src[ptr & 255];
    end
    if (o_ready) saw_ready = 1'b1;
    if (o_done) done_cnt++;
  endtask

  task automatic load();
    ptr = 0;
    din = src[0];
  endtask

  task automatic tick(input int gap);
    bit_tick = 1'b1;
    cyc();
    bit_tick = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    last_tx = o_tx; last_active = o_active; last_done = o_done; last_underrun = o_underrun;
    for (int i = 1; i < gap; i++) cyc();
  endtask

  // Expected line bit for tick t (1-based) of a frame.
  function automatic logic exp_bit(input int t, input int nd, input logic [127:0] sw, input int ln);
    int k;
    int b;
    logic [7:0] byt;
    if (t <= nd) return sw[nd - t];
    if (t <= nd + 8 * ln) begin
      k = (t - nd - 1) / 8;
      b = (t - nd - 1) % 8;
      byt = src[k];
      return byt[7 - b];
    end
    return 1'b0;
  endfunction

  // Runs ticks until the frame closes (tx_active drops) or max_t ticks.
  task automatic run_frame(input int gap, input int nd, input logic [127:0] sw, input int ln,
                           input int max_t, input int mid, output int nt, output int nbad,
                           output logic [63:0] bits);
    nt = 0; nbad = 0; bits = '0;
    while (nt < max_t) begin
      if (nt == mid) begin
        if (sel) start_b = 1'b1; else start_a = 1'b1;
      end
      tick(gap);
      nt++;
      if (!last_active) break;
      bits = {bits[62:0], last_tx};
      if (last_tx !== exp_bit(nt, nd, sw, ln)) nbad++;
    end
  endtask

  int          nt, nbad;
  logic [63:0] bits;

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; bit_tick = 1'b0; din = 8'h00;
    din_valid = 1'b0; len = 8'd0; sel = 1'b0; ptr = 0; saw_ready = 1'b0; done_cnt = 0;
    for (int i = 0; i < 256; i++) src[i] = 8'(i * 37 + 11);
    repeat (3) cyc();
    chk("rst_tx", o_tx, 0);
    chk("rst_active", o_active, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_done", o_done, 0);
    chk("rst_underrun", o_underrun, 0);
    chk("rst_b_active", tx_active_b, 0);
    rst = 1'b0;
    cyc();

    // Test 1: nominal frame, len=2, bytes 3C 81, tick every 4 cycles.
    src[0] = 8'h3C; src[1] = 8'h81;
    load(); din_valid = 1'b1; len = 8'd2; done_cnt = 0;
    start_a = 1'b1; cyc(); start_a = 1'b0;
    chk("t1_active_rise", o_active, 1);
    chk("t1_tx_idle", o_tx, 0);
    repeat (3) cyc();
    run_frame(4, 16, 128'hA5C3, 2, 60, -1, nt, nbad, bits);
    chk("t1_ticks", nt, 33);
    chk("t1_bits", bits[31:0], 32'hA5C33C81);
    chk("t1_model", nbad, 0);
    chk("t1_done", last_done, 1);
    chk("t1_close_tx", last_tx, 0);
    chk("t1_underrun", last_underrun, 0);
    repeat (4) cyc();
    chk("t1_done_once", done_cnt, 1);

    // Test 2: sync only.
    len = 8'd0; saw_ready = 1'b0; done_cnt = 0;
    start_a = 1'b1; cyc(); start_a = 1'b0;
    run_frame(3, 16, 128'hA5C3, 0, 40, -1, nt, nbad, bits);
    chk("t2_ticks", nt, 17);
    chk("t2_bits", bits[31:0], 32'h0000A5C3);
    chk("t2_done", last_done, 1);
    chk("t2_no_ready", saw_ready, 0);

    // Test 3: underrun with din_valid low.
    len = 8'd1; din_valid = 1'b0; load(); done_cnt = 0;
    start_a = 1'b1; cyc(); start_a = 1'b0;
    run_frame(2, 16, 128'hA5C3, 1, 40, -1, nt, nbad, bits);
    chk("t3_ticks", nt, 17);
    chk("t3_model", nbad, 0);
    chk("t3_underrun", last_underrun, 1);
    chk("t3_tx", last_tx, 0);
    chk("t3_no_done", last_done, 0);
    repeat (3) cyc();
    chk("t3_done_cnt", done_cnt, 0);
    chk("t3_sticky", o_underrun, 1);
    din_valid = 1'b1; len = 8'd0;
    start_a = 1'b1; cyc(); start_a = 1'b0;
    chk("t3_cleared", o_underrun, 0);
    run_frame(2, 16, 128'hA5C3, 0, 40, -1, nt, nbad, bits);
    chk("t3_next_ticks", nt, 17);

    // Test 4a: start coincident with bit_tick emits nothing.
    len = 8'd0;
    start_a = 1'b1; bit_tick = 1'b1; cyc(); start_a = 1'b0; bit_tick = 1'b0;
    chk("t4_active", o_active, 1);
    chk("t4_no_bit", o_tx, 0);
    cyc();
    run_frame(2, 16, 128'hA5C3, 0, 40, -1, nt, nbad, bits);
    chk("t4_ticks", nt, 17);
    chk("t4_bits", bits[31:0], 32'h0000A5C3);
    // Test 4b: start pulsed mid-frame and len changed: both ignored.
    len = 8'd1; load();
    start_a = 1'b1; cyc(); start_a = 1'b0;
    len = 8'd9;
    run_frame(2, 16, 128'hA5C3, 1, 60, 5, nt, nbad, bits);
    chk("t4_mid_ticks", nt, 25);
    chk("t4_mid_model", nbad, 0);
    chk("t4_mid_done", last_done, 1);

    // Test 5: reset after tick 10 of a len=3 frame.
    len = 8'd3; load();
    start_a = 1'b1; cyc(); start_a = 1'b0;
    run_frame(2, 16, 128'hA5C3, 3, 10, -1, nt, nbad, bits);
    chk("t5_pre_tx", o_tx, 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t5_tx", o_tx, 0);
    chk("t5_active", o_active, 0);
    chk("t5_ready", o_ready, 0);
    chk("t5_done", o_done, 0);
    chk("t5_underrun", o_underrun, 0);
    cyc();
    load();
    start_a = 1'b1; cyc(); start_a = 1'b0;
    run_frame(2, 16, 128'hA5C3, 3, 60, -1, nt, nbad, bits);
    chk("t5_ticks", nt, 41);
    chk("t5_model", nbad, 0);
    chk("t5_close_done", last_done, 1);

    // Test 6: NDATA=128, len=255 at max tick rate, then back-to-back frame.
    sel = 1'b1;
    for (int i = 0; i < 256; i++) src[i] = 8'(i * 37 + 11);
    len = 8'd255; load(); din_valid = 1'b1;
    start_b = 1'b1; cyc(); start_b = 1'b0;
    run_frame(1, 128, {8{16'hA5C3}}, 255, 2300, -1, nt, nbad, bits);
    chk("t6_ticks", nt, 2169);
    chk("t6_model", nbad, 0);
    chk("t6_done", last_done, 1);
    chk("t6_close_tx", last_tx, 0);
    len = 8'd2; load();
    start_b = 1'b1; bit_tick = 1'b1; cyc(); start_b = 1'b0; bit_tick = 1'b0;
    chk("t6_b2b_active", o_active, 1);
    chk("t6_b2b_tx", o_tx, 0);
    run_frame(1, 128, {8{16'hA5C3}}, 2, 200, -1, nt, nbad, bits);
    chk("t6_b2b_ticks", nt, 145);
    chk("t6_b2b_model", nbad, 0);
    chk("t6_b2b_done", last_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
